// File: rtl/i2c_config_sequencer.sv
// Boot-time I2C register programmer: divides CLOCK down to the engine clock and walks a
// {sub_addr, data} table through the GO/END/ACK write engine. Optional: I2C_CFG_RETRY_EN.
module i2c_config_sequencer #(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         I2C_FREQ      = 20_000,
    parameter int         LUT_SIZE      = 16,
    parameter logic [7:0] SLAVE_ADDR    = 8'h34,
    parameter int         POWERUP_TICKS = 1000,
    parameter int         MAX_RETRY     = 3
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [15:0] LUT_DATA,
    output logic [7:0]  LUT_INDEX,
    output logic        CTRL_CLK,
    output logic [23:0] I2C_DATA,
    output logic        GO,
    output logic        W_R,
    input  logic        END,
    input  logic [2:0]  ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR
);

    localparam int HALF  = CLK_FREQ / (2 * I2C_FREQ);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_NEXT, S_DONE, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               clk_q, clk_d;
    logic               start_q, start_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         idx_q, idx_d;
    logic [23:0]        data_q, data_d;
    logic               go_q, go_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               nack_q, nack_d;
    logic               tick, start_rise, restart_ok, restart;
`ifdef I2C_CFG_RETRY_EN
    localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;
    logic [RTY_W-1:0]   retry_q, retry_d;
`endif

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            clk_q   <= 1'b0;
            start_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            nack_q  <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            start_q <= start_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            go_q    <= go_d;
            done_q  <= done_d;
            err_q   <= err_d;
            nack_q  <= nack_d;
`ifdef I2C_CFG_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        clk_d   = clk_q;
        start_d = START;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        go_d    = go_q;
        done_d  = done_q;
        err_d   = err_q;
        nack_d  = nack_q;
        tick    = 1'b0;
`ifdef I2C_CFG_RETRY_EN
        retry_d = retry_q;
`endif

        // tick marks the rising toggle of CTRL_CLK; the FSM only moves on it
        if (div_q == DIV_W'(HALF - 1)) begin
            div_d = '0;
            clk_d = ~clk_q;
            tick  = ~clk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        restart_ok = (state_q == S_DONE) || (state_q == S_FAIL);
        start_rise = START & ~start_q;
        restart    = pend_q | (start_rise & restart_ok);
        if (tick)
            pend_d = 1'b0;
        else if (start_rise && restart_ok)
            pend_d = 1'b1;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PWRUP;
                    cnt_d   = '0;
                end
                S_PWRUP: begin
                    if (cnt_q == CNT_W'(POWERUP_TICKS - 1)) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    // second tick in LOAD gives the engine time to drop END
                    if (cnt_q == '0) begin
                        data_d = {SLAVE_ADDR, LUT_DATA};
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = S_ISSUE;
                        cnt_d   = '0;
                    end
                end
                S_ISSUE: begin
                    go_d    = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
                S_WAIT: begin
                    if (cnt_q >= CNT_W'(3) && END) begin
                        nack_d  = |ACK;
                        state_d = S_CHECK;
                        cnt_d   = '0;
                    end else if (cnt_q < CNT_W'(3)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    go_d = 1'b0;
                    if (!nack_q) begin
                        state_d = S_NEXT;
`ifdef I2C_CFG_RETRY_EN
                    end else if (retry_q == RTY_W'(MAX_RETRY)) begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end
`else
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_NEXT;
                    end
`endif
                end
                S_NEXT: begin
`ifdef I2C_CFG_RETRY_EN
                    retry_d = '0;
`endif
                    if (idx_q == 8'(LUT_SIZE - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end
                end
                S_DONE, S_FAIL: begin
                    if (restart) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = S_LOAD;
`ifdef I2C_CFG_RETRY_EN
                        retry_d = '0;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign LUT_INDEX = idx_q;
    assign CTRL_CLK  = clk_q;
    assign I2C_DATA  = data_q;
    assign GO        = go_q;
    assign W_R       = 1'b0;
    assign DONE      = done_q;
    assign ERROR     = err_q;
    assign BUSY      = (state_q == S_PWRUP) || (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT)  || (state_q == S_CHECK) || (state_q == S_NEXT);

endmodule

// File: doc/i2c_config_sequencer.md
# i2c_config_sequencer

Boot-time register programmer that sits in front of the three-byte I2C write engine (`GO`/`END`/`ACK` handshake, 24-bit `{slave, sub, data}` word). It generates the engine's slow clock, then walks an external table of `{sub_addr, data}` entries. For each entry it issues one transaction and checks the 3-bit acknowledge. It reports completion or failure to the rest of the design, e.g. for codec or camera setup.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `I2C_FREQ`, 20_000: engine clock (SCL) frequency in Hz.
- `LUT_SIZE`, 16: number of table entries, 1..255.
- `SLAVE_ADDR`, 8'h34: 8-bit write address placed in `I2C_DATA[23:16]`.
- `POWERUP_TICKS`, 1000: engine ticks to wait after reset before the first entry.
- `MAX_RETRY`, 3: retries per entry. Only used with `I2C_CFG_RETRY_EN`.

Ports:
- `CLOCK` in 1: system clock.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `START` in 1: rising edge re-runs the whole table. Only honoured in DONE or FAIL.
- `LUT_DATA` in 16: `{sub_addr, data}` for `LUT_INDEX`. Combinational table, valid in the same cycle.
- `LUT_INDEX` out 8: current table entry.
- `CTRL_CLK` out 1: square-wave clock for the engine.
- `I2C_DATA` out 24: `{SLAVE_ADDR, LUT_DATA}`, registered.
- `GO` out 1: engine start level.
- `W_R` out 1: constant 0 (write).
- `END` in 1: engine done level.
- `ACK` in 3: engine acknowledge bits. 0 means ACK; any 1 bit means NACK.
- `BUSY` out 1: table walk in progress.
- `DONE` out 1: table completed.
- `ERROR` out 1: at least one entry failed.

## Operation
- Divider: counter in `CLOCK` domain with half-period `HALF = CLK_FREQ/(2*I2C_FREQ)`.
  - `CTRL_CLK` toggles when the counter reaches `HALF-1`, then the counter wraps to 0.
  - `tick` is an internal 1-cycle pulse on each 0->1 toggle.
  - All FSM transitions below occur only on `tick` cycles.
- States:
  - IDLE: entered on reset; goes to PWRUP on the next tick.
  - PWRUP: counts `POWERUP_TICKS` ticks, then goes to LOAD with `LUT_INDEX`=0.
  - LOAD: registers `I2C_DATA`; holds `GO`=0; requires 2 ticks in LOAD so the engine clears `END`; then goes to ISSUE.
  - ISSUE: sets `GO`=1; goes to WAIT.
  - WAIT: ignores `END` for the first 3 ticks (stale-END guard). On the first later tick with `END`=1, samples `ACK` and goes to CHECK.
  - CHECK: drops `GO`=0. If `ACK`==0, goes to NEXT. If NACK, applies the failure rule (Configuration).
  - NEXT: if `LUT_INDEX`==`LUT_SIZE-1`, goes to DONE. Otherwise increments the index and goes to LOAD.
  - DONE: `DONE`=1, `BUSY`=0, `GO`=0.
  - FAIL: `BUSY`=0, `ERROR`=1, `DONE`=0.
- Restart: a `START` rising edge (edge-detected in `CLOCK` domain, latched until the next tick) in DONE or FAIL does the following:
  - clears `DONE` and `ERROR`;
  - sets `LUT_INDEX`=0;
  - goes to LOAD, skipping PWRUP.
  - `START` in any other state is ignored and not latched.
- `BUSY`=1 in PWRUP through NEXT.
- `END` stuck at 0 has no timeout: the FSM stays in WAIT.

## Timing
- Reset values:
  - outputs: `GO`=0, `I2C_DATA`=0, `LUT_INDEX`=0, `CTRL_CLK`=0, `W_R`=0, `BUSY`=0, `DONE`=0, `ERROR`=0;
  - internal: divider=0, state=IDLE.
- Reset mid-transaction takes effect immediately (asynchronously): `GO` falls, which aborts the engine. The walk restarts with PWRUP after reset deasserts.
- Per entry, in ticks: LOAD 2 + ISSUE 1 + WAIT ≥4 + CHECK 1 + NEXT 1. The engine needs 33 ticks after `GO`, so an entry takes about 38 ticks.
- `I2C_DATA` is stable from LOAD until CHECK. It never changes while `GO`=1.
- `GO`, `DONE` and `ERROR` change only on `tick` cycles. `LUT_INDEX` is an 8-bit counter and never wraps, because NEXT stops at `LUT_SIZE-1`.

## Configuration
- `I2C_CFG_RETRY_EN`
  - Defined: on NACK, a per-entry retry counter increments and the FSM returns to LOAD with the same index. After `MAX_RETRY` retries with NACK it goes to FAIL and stops; `LUT_INDEX` holds the failing entry. The retry counter clears on NEXT.
  - Undefined: on NACK, sets sticky `ERROR`=1 and continues to NEXT. The walk always ends in DONE; `DONE` and `ERROR` can both be 1.

## Test plan
- `CLK_FREQ`=1e6, `I2C_FREQ`=1e5, `LUT_SIZE`=4, engine model always ACK=000 -> `CTRL_CLK` period 10 cycles; 4 transactions with `I2C_DATA`={34,LUT_DATA}; `DONE`=1, `ERROR`=0, `LUT_INDEX`=3.
- Engine model returns ACK=010 on entry 2:
  - retry enabled, `MAX_RETRY`=3 -> 4 `GO` pulses on index 2, then FAIL with `ERROR`=1, `DONE`=0, `LUT_INDEX`=2;
  - retry disabled -> 4 entries issued once each; `DONE`=1 and `ERROR`=1.
- NACK on the first attempt of entry 1, then ACK (retry enabled) -> 2 transactions at index 1; finishes with `DONE`=1, `ERROR`=0.
- Stale `END`=1 held during the first 3 WAIT ticks, then 0, then 1 -> no advance until the later `END`=1.
- `RESET_N` pulsed low in WAIT of entry 1 -> `GO`=0 immediately; all outputs at reset values; the walk restarts from PWRUP at index 0.
- `START` pulse while `BUSY` -> ignored. `START` pulse in DONE -> `DONE` clears, the table is replayed without PWRUP delay.
